fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage that sits directly upstream of the instruction memory and feeds decode. It holds the program counter, drives the 30-bit word address into the instruction memory, captures the combinationally returned instruction word with its PC into a 2-entry skid buffer, and presents it to decode over a valid/ready handshake. Taken branches and jumps redirect the PC and flush the buffer.

## Interface
- RESET_PC, 32'h0100_0000: byte PC after reset; word address 30'h0040_0000, the first word of the text segment.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- read_addr  out  30  word address to the instruction memory; equals pc[31:2], combinational from the PC register.
- mem_inst  in  32  instruction word returned by the memory for read_addr in the same cycle.
- redirect  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  new byte PC; bits [1:0] ignored.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  32  head instruction word.
- out_pc  out  32  byte PC of out_inst.
- halted  out  1  null-op halt flag; see Configuration.

## Operation
- State: pc[31:0], 2-entry FIFO of {pc, inst}, count[1:0] in 0..2, halted.
- pop = out_valid & out_ready. push = ~redirect & ~halted & (count < 2) & ~null_stop.
- null_stop = mem_inst == 32'h0 when FETCH_NULL_HALT_EN is defined; otherwise constant 0.
- On push: write {pc, mem_inst} at the tail, then pc <= pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- On pop: advance the head.
- count_next = count + push - pop. Push and pop in the same cycle are legal at count 1 (count stays 1) and at count 0 cannot occur. At count 2 no push occurs, and pop alone takes count to 1.
- Redirect has top priority:
  - pc <= {redirect_pc[31:2], 2'b00}.
  - count <= 0, all buffered entries discarded.
  - No push that cycle; any pop that cycle still counts as accepted by decode.
- out_inst/out_pc show the head entry. When count is 0 they are held at their last value.
- Reset values:
  - pc = RESET_PC, so read_addr = RESET_PC[31:2].
  - count = 0, out_valid = 0, out_inst = 0, out_pc = 0, halted = 0.
  - Reset asserted mid-stream discards everything, with no partial push.

## Timing
- Fetch-to-output latency is 1 cycle. Address is presented in cycle N and the instruction is captured at edge N; out_valid is high in cycle N+1.
- Throughput is 1 instruction/cycle while out_ready is held high (count stays 1).
- out_ready low for k cycles fills the buffer in 2 cycles. The PC then stalls, and read_addr stays stable until a pop frees a slot.
- Redirect asserted in cycle N:
  - out_valid = 0 in N+1.
  - read_addr = redirect_pc[31:2] in N+1.
  - First target instruction is valid in N+2.
- out_valid/out_inst/out_pc are registered; no combinational path from out_ready to out_valid. read_addr depends only on pc.

## Configuration
- Macro FETCH_NULL_HALT_EN.
- Defined:
  - A would-be push with mem_inst == 0 does not push, does not advance pc, and sets halted = 1 on that edge.
  - halted is sticky until reset; redirect does not clear it.
  - Entries already buffered still drain to decode.
- Undefined:
  - 32'h0 (sll $0,$0,0) is fetched as a normal nop.
  - halted is tied to 0.

## Test plan
- Reset release with out_ready = 1 and memory words A,B,C at 0x400000.. -> read_addr 0x400000, 0x400001, 0x400002. out_valid rises 1 cycle after release, and out_pc shows 0x0100_0000, 0x0100_0004, 0x0100_0008 with out_inst A,B,C on consecutive cycles.
- Backpressure with out_ready = 0 for 5 cycles after the first valid -> count reaches 2 and read_addr freezes at 0x400002. Releasing out_ready delivers B then C with no loss or duplication.
- Redirect to 32'h0100_0043 while count = 2 -> next cycle out_valid = 0 and read_addr = 0x400010. The cycle after, out_pc = 0x0100_0040.
- PC at 32'hFFFF_FFFC with out_ready = 1 -> next read_addr = 0, and out_pc shows 0xFFFF_FFFC then 0x0000_0000.
- Zero word at 0x400003 with FETCH_NULL_HALT_EN defined -> A,B,C delivered, halted = 1 at the edge that sees the zero, read_addr holds 0x400003, and out_valid drops after C. Without the macro, 32'h0 is delivered and halted stays 0.
- Reset asserted mid-stream between clock edges -> out_valid, halted and count clear immediately, and read_addr returns to 0x400000 without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, combinational memory address, and a 2-entry skid buffer
// feeding decode. Define FETCH_NULL_HALT_EN to stop fetching (sticky halt) on an all-zero word.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [29:0] read_addr,
  input  logic [31:0] mem_inst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        halted
);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] head_inst_q, head_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;

  logic full;
  logic pop;
  logic push;
  logic null_stop;

  // Byte-offset bits of a redirect target carry no information for word fetch.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign read_addr = pc_q[31:2];
  assign out_valid = |count_q;
  assign out_inst  = head_inst_q;
  assign out_pc    = head_pc_q;

  assign full = (count_q == 2'd2);
  assign pop  = out_valid & out_ready;
  assign push = ~redirect & ~halted & ~full & ~null_stop;

`ifdef FETCH_NULL_HALT_EN
  logic halted_q, halted_d;

  assign null_stop = (mem_inst == 32'h0);
  assign halted    = halted_q;

  // A fetch that would have pushed a zero word halts instead; sticky until reset.
  always_comb begin
    halted_d = halted_q;
    if (~redirect & ~halted_q & ~full & null_stop) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end
`else
  assign null_stop = 1'b0;
  assign halted    = 1'b0;
`endif

  always_comb begin
    pc_d        = pc_q;
    count_d     = count_q;
    head_pc_d   = head_pc_q;
    head_inst_d = head_inst_q;
    skid_pc_d   = skid_pc_q;
    skid_inst_d = skid_inst_q;

    if (redirect) begin
      // Flush: entries are dropped, head data is left as-is (outputs hold while empty).
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 2'd0;
    end else begin
      if (push) begin
        pc_d = pc_q + 32'd4;
      end
      case (count_q)
        2'd0: begin
          if (push) begin
            head_pc_d   = pc_q;
            head_inst_d = mem_inst;
            count_d     = 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_pc_d   = pc_q;
            head_inst_d = mem_inst;
          end else if (push) begin
            skid_pc_d   = pc_q;
            skid_inst_d = mem_inst;
            count_d     = 2'd2;
          end else if (pop) begin
            count_d = 2'd0;
          end
        end
        2'd2: begin
          if (pop) begin
            head_pc_d   = skid_pc_q;
            head_inst_d = skid_inst_q;
            count_d     = 2'd1;
          end
        end
        default: begin
          count_d = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      count_q     <= 2'd0;
      head_pc_q   <= 32'h0;
      head_inst_q <= 32'h0;
      skid_pc_q   <= 32'h0;
      skid_inst_q <= 32'h0;
    end else begin
      pc_q        <= pc_d;
      count_q     <= count_d;
      head_pc_q   <= head_pc_d;
      head_inst_q <= head_inst_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/redirect traffic, checked by a
// queue-based reference model in a negedge monitor.
module tb_fetch_unit;

  localparam logic [31:0] ResetPc = 32'h0100_0000;

  logic        clk;
  logic        reset;
  logic [29:0] read_addr;
  logic [31:0] mem_inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;

  // Memory image: address-derived nonzero words, with one optional zero word.
  logic        zero_en;
  logic [29:0] zero_addr;
  logic [31:0] salt;

  int n_tests;
  int n_fail;

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .read_addr  (read_addr),
    .mem_inst   (mem_inst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_inst   (out_inst),
    .out_pc     (out_pc),
    .halted     (halted)
  );

  assign mem_inst = (zero_en && read_addr == zero_addr) ? 32'h0
                  : ({read_addr, 2'b11} ^ {salt[31:2], 2'b00});

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (zero_en && a == zero_addr) return 32'h0;
    return {a, 2'b11} ^ {salt[31:2], 2'b00};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-order PC plus a bounded queue of expected {pc, inst}.
`ifdef FETCH_NULL_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic [63:0] exp_q[$];
  logic [31:0] mpc;
  logic        mhalt;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      mpc   = ResetPc;
      mhalt = 1'b0;
      check("reset_valid", {31'h0, out_valid}, 32'h0);
      check("reset_addr", {2'b00, read_addr}, {2'b00, ResetPc[31:2]});
      check("reset_halted", {31'h0, halted}, 32'h0);
    end else begin
      bit          was_full;
      logic [31:0] w;
      check("valid", {31'h0, out_valid}, {31'h0, exp_q.size() != 0});
      check("read_addr", {2'b00, read_addr}, {2'b00, mpc[31:2]});
      check("halted", {31'h0, halted}, {31'h0, mhalt});
      if (exp_q.size() != 0) begin
        check("out_pc", out_pc, exp_q[0][63:32]);
        check("out_inst", out_inst, exp_q[0][31:0]);
      end
      was_full = (exp_q.size() == 2);
      if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
      if (redirect) begin
        exp_q.delete();
        mpc = {redirect_pc[31:2], 2'b00};
      end else if (!mhalt && !was_full) begin
        w = mem_word(mpc[31:2]);
        if (HaltEn && w == 32'h0) begin
          mhalt = 1'b1;
        end else begin
          exp_q.push_back({mpc, w});
          mpc = mpc + 32'd4;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    zero_en     = 1'b0;
    zero_addr   = 30'h0;
    salt        = 32'h0;
    tick();
    tick();

    // Reset release streaming, then backpressure from the first valid cycle.
    out_ready = 1'b1;
    reset     = 1'b0;
    check("rel_addr0", {2'b00, read_addr}, 32'h0040_0000);
    tick();
    check("first_valid", {31'h0, out_valid}, 32'h1);
    check("first_pc", out_pc, 32'h0100_0000);
    check("rel_addr1", {2'b00, read_addr}, 32'h0040_0001);
    out_ready = 1'b0;
    repeat (5) tick();
    check("stall_addr", {2'b00, read_addr}, 32'h0040_0002);
    check("stall_valid", {31'h0, out_valid}, 32'h1);
    out_ready = 1'b1;
    repeat (6) tick();

    // Fill the buffer, then redirect while full.
    out_ready = 1'b0;
    repeat (3) tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0100_0043;
    tick();
    redirect = 1'b0;
    check("redir_valid", {31'h0, out_valid}, 32'h0);
    check("redir_addr", {2'b00, read_addr}, 32'h0040_0010);
    tick();
    check("redir_valid2", {31'h0, out_valid}, 32'h1);
    check("redir_pc", out_pc, 32'h0100_0040);
    out_ready = 1'b1;
    repeat (4) tick();

    // PC wrap.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("wrap_addr0", {2'b00, read_addr}, 32'h3FFF_FFFF);
    tick();
    check("wrap_addr1", {2'b00, read_addr}, 32'h0);
    check("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc1", out_pc, 32'h0);
    repeat (2) tick();

    // Zero word at 0x400003.
    reset = 1'b1;
    tick();
    zero_en   = 1'b1;
    zero_addr = 30'h040_0003;
    tick();
    reset = 1'b0;
    repeat (8) tick();
`ifdef FETCH_NULL_HALT_EN
    check("null_halted", {31'h0, halted}, 32'h1);
    check("null_addr", {2'b00, read_addr}, 32'h0040_0003);
    check("null_valid", {31'h0, out_valid}, 32'h0);
    redirect    = 1'b1;
    redirect_pc = 32'h0100_0100;
    tick();
    redirect = 1'b0;
    tick();
    check("null_sticky", {31'h0, halted}, 32'h1);
`else
    check("null_nohalt", {31'h0, halted}, 32'h0);
    check("null_valid", {31'h0, out_valid}, 32'h1);
`endif

    // Reset asserted between clock edges mid-stream.
    reset = 1'b1;
    tick();
    zero_en = 1'b0;
    reset   = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_valid", {31'h0, out_valid}, 32'h0);
    check("async_halted", {31'h0, halted}, 32'h0);
    check("async_addr", {2'b00, read_addr}, 32'h0040_0000);
    tick();
    salt  = $urandom;
    reset = 1'b0;

    // Random ready/redirect traffic.
    for (int i = 0; i < 3000; i++) begin
      out_ready = ($urandom % 4) != 0;
      redirect  = ($urandom % 12) == 0;
      if ($urandom % 4 == 0) redirect_pc = 32'hFFFF_FFF0 + ($urandom % 16);
      else redirect_pc = $urandom;
      tick();
    end
    redirect = 1'b0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
